// File: rtl/clk_reset_sequencer.sv
// Staged reset release for the single-cycle RISC-V core, driven by clock-wizard lock.
// Memories leave reset once lock has been stable for a while; the core follows after a gap.
module clk_reset_sequencer #(
    parameter int unsigned LOCK_STABLE_CYCLES = 16,
    parameter int unsigned STAGE_GAP_CYCLES   = 4,
    parameter int unsigned CNT_W              = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    input  logic             ext_reset_req,
    output logic             mem_reset,
    output logic             core_reset,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lock_loss_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        REL_MEM   = 2'd2,
        RUN       = 2'd3
    } state_e;

    localparam logic [7:0] STABLE_LAST = 8'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST    = 8'(STAGE_GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] loss_q, loss_d;
    logic             sync1_q, sync2_q;
    logic             mem_reset_q, core_reset_q, ready_q;
    logic             locked_s;

    assign locked_s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (ext_reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = REL_MEM;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            REL_MEM, RUN: begin
                // Loss after memory release is the only event worth counting for debug.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                    loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
                end else if (ext_reset_req) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (state_q == REL_MEM) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= '0;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            mem_reset_q  <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            sync1_q      <= locked;
            sync2_q      <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            mem_reset_q  <= (state_d == WAIT_LOCK) || (state_d == STABLE);
            core_reset_q <= (state_d != RUN);
            ready_q      <= (state_d == RUN);
        end
    end

    assign mem_reset       = mem_reset_q;
    assign core_reset      = core_reset_q;
    assign ready           = ready_q;
    assign state           = state_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer: checkpoint table, saturation sequence, and random lock/request traffic
// against a timer-based reference model.
module tb_clk_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked = 1'b0;
    logic       ext_reset_req = 1'b0;
    logic       mem_reset, core_reset, ready;
    logic [1:0] state;
    logic [7:0] lock_loss_count;
    logic       mem_reset2, core_reset2, ready2;
    logic [1:0] state2;
    logic [1:0] lock_loss_count2;

    always #5 clk = ~clk;

    clk_reset_sequencer dut (
        .clk(clk), .reset(reset), .locked(locked), .ext_reset_req(ext_reset_req),
        .mem_reset(mem_reset), .core_reset(core_reset), .ready(ready),
        .state(state), .lock_loss_count(lock_loss_count)
    );

    clk_reset_sequencer #(
        .LOCK_STABLE_CYCLES(3),
        .STAGE_GAP_CYCLES(2),
        .CNT_W(2)
    ) dut2 (
        .clk(clk), .reset(reset), .locked(locked), .ext_reset_req(ext_reset_req),
        .mem_reset(mem_reset2), .core_reset(core_reset2), .ready(ready2),
        .state(state2), .lock_loss_count(lock_loss_count2)
    );

    // Reference: "armed" means lock was seen; age counts edges since (re)entering the stable phase.
    typedef struct {
        bit armed;
        int age;
        int cnt;
        bit h0;
        bit h1;
    } mdl_t;

    typedef struct {
        int n;
        bit rst;
        bit lk;
        bit ext;
        int st;
        bit mem;
        bit core;
        bit rdy;
        int cnt;
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    mdl_t m1, m2;
    vec_t tbl[$];

    function automatic mdl_t step(input mdl_t m, input int lsc, input int sg, input int cmax,
                                  input bit rst, input bit lk, input bit ext);
        mdl_t n;
        bit   ls;
        n  = m;
        ls = m.h1;
        if (rst) begin
            n.armed = 0; n.age = 0; n.cnt = 0; n.h0 = 0; n.h1 = 0;
            return n;
        end
        n.h1 = m.h0;
        n.h0 = lk;
        if (!m.armed) begin
            if (ls) begin
                n.armed = 1;
                n.age   = 0;
            end
        end else if (!ls) begin
            if (m.age >= lsc && m.cnt < cmax) n.cnt = m.cnt + 1;
            n.armed = 0;
            n.age   = 0;
        end else if (ext) begin
            n.age = 0;
        end else if (m.age < lsc + sg) begin
            n.age = m.age + 1;
        end
        return n;
    endfunction

    function automatic int mstate(input mdl_t m, input int lsc, input int sg);
        if (!m.armed) return 0;
        if (m.age < lsc) return 1;
        if (m.age < lsc + sg) return 2;
        return 3;
    endfunction

    function automatic int ctl(input int st);
        int mem, core, rdy;
        mem  = (st < 2) ? 1 : 0;
        core = (st != 3) ? 1 : 0;
        rdy  = (st == 3) ? 1 : 0;
        return st * 8 + mem * 4 + core * 2 + rdy;
    endfunction

    function automatic vec_t mkv(input int n, input bit rst, input bit lk, input bit ext,
                                 input int st, input bit mem, input bit core, input bit rdy,
                                 input int cnt);
        vec_t v;
        v.n = n; v.rst = rst; v.lk = lk; v.ext = ext;
        v.st = st; v.mem = mem; v.core = core; v.rdy = rdy; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic tick(input bit r, input bit lk, input bit e);
        @(negedge clk);
        reset         = r;
        locked        = lk;
        ext_reset_req = e;
        @(posedge clk);
        m1 = step(m1, 16, 4, 255, r, lk, e);
        m2 = step(m2, 3, 2, 3, r, lk, e);
        #1;
        cyc++;
        chk("model_ctl", int'({state, mem_reset, core_reset, ready}), ctl(mstate(m1, 16, 4)));
        chk("model_cnt", int'(lock_loss_count), m1.cnt);
        chk("model2_ctl", int'({state2, mem_reset2, core_reset2, ready2}), ctl(mstate(m2, 3, 2)));
        chk("model2_cnt", int'(lock_loss_count2), m2.cnt);
        chk("invariant", int'(!core_reset && mem_reset), 0);
        chk("invariant2", int'(!core_reset2 && mem_reset2), 0);
    endtask

    initial begin
        int   sat_exp[5];
        bit   lk;
        bit   ex;
        bit   rs;
        vec_t v;

        m1 = '{0, 0, 0, 0, 0};
        m2 = '{0, 0, 0, 0, 0};

        // Checkpoints for the default instance: {n, rst, lk, ext, state, mem, core, ready, count}
        tbl.push_back(mkv(2,  1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(2,  0, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(1,  0, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(15, 0, 1, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mkv(1,  0, 1, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mkv(3,  0, 1, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mkv(1,  0, 1, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mkv(5,  0, 1, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mkv(2,  0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mkv(1,  0, 0, 0, 0, 1, 1, 0, 1));
        tbl.push_back(mkv(22, 0, 1, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mkv(1,  0, 1, 0, 3, 0, 0, 1, 1));
        tbl.push_back(mkv(1,  0, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mkv(19, 0, 1, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mkv(1,  0, 1, 0, 3, 0, 0, 1, 1));
        tbl.push_back(mkv(5,  0, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mkv(16, 0, 1, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mkv(1,  0, 1, 1, 1, 1, 1, 0, 1));
        tbl.push_back(mkv(17, 0, 1, 0, 2, 0, 1, 0, 1));
        tbl.push_back(mkv(1,  1, 1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mkv(22, 0, 1, 0, 2, 0, 1, 0, 0));
        tbl.push_back(mkv(1,  0, 1, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mkv(2,  0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(mkv(1,  0, 0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mkv(3,  0, 0, 1, 0, 1, 1, 0, 1));
        for (int r = 0; r < 3; r++) begin
            tbl.push_back(mkv(5, 0, 1, 0, 1, 1, 1, 0, 1));
            tbl.push_back(mkv(3, 0, 0, 0, 0, 1, 1, 0, 1));
        end

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            for (int k = 0; k < v.n; k++) tick(v.rst, v.lk, v.ext);
            chk($sformatf("vec%0d_ctl", i), int'({state, mem_reset, core_reset, ready}),
                v.st * 8 + int'(v.mem) * 4 + int'(v.core) * 2 + int'(v.rdy));
            chk($sformatf("vec%0d_cnt", i), int'(lock_loss_count), v.cnt);
        end

        // Narrow counter instance: repeated loss from RUN must saturate at 3.
        sat_exp[0] = 1; sat_exp[1] = 2; sat_exp[2] = 3; sat_exp[3] = 3; sat_exp[4] = 3;
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("sat_reset_cnt", int'(lock_loss_count2), 0);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 10; k++) tick(0, 1, 0);
            chk($sformatf("sat%0d_run", i), int'(state2), 3);
            for (int k = 0; k < 3; k++) tick(0, 0, 0);
            chk($sformatf("sat%0d_state", i), int'(state2), 0);
            chk($sformatf("sat%0d_cnt", i), int'(lock_loss_count2), sat_exp[i]);
        end

        // Random traffic: sticky lock with occasional drops, sporadic requests and resets.
        lk = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            ex = ($urandom_range(0, 29) == 0);
            rs = ($urandom_range(0, 599) == 0);
            tick(rs, lk, ex);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
